// File: rtl/seg_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : seg_pkg                                                    |
// | Description : Shared definitions for the seven-segment scan driver:      |
// |               scan-state encodings, active-low hex glyph table           |
// |               ({g,f,e,d,c,b,a}) and a counter-width helper.              |
// | Ports       : none (package)                                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package seg_pkg;

    // Scan states
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_blank = 2'd1;
    localparam logic [1:0] c_st_on    = 2'd2;

    // All cathodes off (active-low)
    localparam logic [6:0] c_seg_off = 7'h7F;

    // Active-low glyphs, index = nibble value. Leftmost entry is nibble F.
    localparam logic [15:0][6:0] c_glyph_tbl = {
        7'h0E,  // F
        7'h06,  // E
        7'h21,  // d
        7'h46,  // C
        7'h03,  // b
        7'h08,  // A
        7'h10,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hex_to_7seg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : hex_to_7seg                                                |
// | Description : Combinational nibble to active-low seven-segment decoder.  |
// | Ports       : i_nibble [3:0] - hex digit to display                      |
// |               o_seg    [6:0] - cathodes {g,f,e,d,c,b,a}, active-low      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module hex_to_7seg
    import seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = c_glyph_tbl[i_nibble];

endmodule
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : seg_scan_driver                                            |
// | Description : Time-multiplexed driver for a common-anode seven-segment   |
// |               display. Each digit slot starts with an anode-off blanking |
// |               interval, the displayed value is latched once per frame,   |
// |               and leading zeros can be suppressed.                       |
// | Ports       : clk, rst         - system clock, sync active-high reset    |
// |               en               - scan enable                             |
// |               value, dp_in     - hex value / decimal points to show      |
// |               an, seg, dp      - active-low registered display drives    |
// |               frame_done       - one-cycle pulse after each full frame   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int CLK_FREQ_HZ   = 100_000_000,
    parameter int REFRESH_HZ    = 1000,
    parameter int NUM_DIGITS    = 4,
    parameter int BLANK_CYCLES  = 16,
    parameter int BLANK_LEADING = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int c_div = CLK_FREQ_HZ / REFRESH_HZ;
    localparam int c_cw  = cnt_width(c_div);
    localparam int c_iw  = cnt_width(NUM_DIGITS);

    localparam logic [c_cw-1:0] c_cnt_one   = c_cw'(1);
    localparam logic [c_cw-1:0] c_div_last  = c_cw'(c_div - 1);
    localparam logic [c_cw-1:0] c_blank_last = c_cw'(BLANK_CYCLES - 1);
    localparam logic [c_iw-1:0] c_idx_one   = c_iw'(1);
    localparam logic [c_iw-1:0] c_idx_last  = c_iw'(NUM_DIGITS - 1);

    // The slot must hold the blanking interval plus at least two lit cycles.
    generate
        if (c_div < BLANK_CYCLES + 2) begin : g_cfg_err
            $error("seg_scan_driver: DIV must be >= BLANK_CYCLES+2");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]              r_state;
    logic [c_cw-1:0]         r_cnt;
    logic [c_iw-1:0]         r_idx;
    logic [4*NUM_DIGITS-1:0] r_shadow_val;
    logic [NUM_DIGITS-1:0]   r_shadow_dp;
    logic [NUM_DIGITS-1:0]   r_an;
    logic [6:0]              r_seg;
    logic                    r_dp;
    logic                    r_frame_done;

    logic [1:0]              w_state_nxt;
    logic [c_cw-1:0]         w_cnt_nxt;
    logic [c_iw-1:0]         w_idx_nxt;
    logic [4*NUM_DIGITS-1:0] w_sval_nxt;
    logic [NUM_DIGITS-1:0]   w_sdp_nxt;
    logic                    w_frame_nxt;

    logic [3:0]              w_nibble;
    logic [6:0]              w_glyph;
    logic [NUM_DIGITS-1:0]   w_an_on;
    logic [NUM_DIGITS-1:0]   w_lz_blank;
    logic                    w_show;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_sval_nxt  = r_shadow_val;
        w_sdp_nxt   = r_shadow_dp;
        w_frame_nxt = 1'b0;

        case (r_state)
            c_st_idle: begin
                if (en) begin
                    w_sval_nxt  = value;
                    w_sdp_nxt   = dp_in;
                    w_idx_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = (BLANK_CYCLES == 0) ? c_st_on : c_st_blank;
                end
            end

            c_st_blank: begin
                if (!en) begin
                    w_state_nxt = c_st_idle;
                end else begin
                    // The slot counter keeps running into the lit phase so
                    // every slot is exactly c_div cycles long.
                    w_cnt_nxt = r_cnt + c_cnt_one;
                    if (r_cnt == c_blank_last) begin
                        w_state_nxt = c_st_on;
                    end
                end
            end

            c_st_on: begin
                if (!en) begin
                    w_state_nxt = c_st_idle;
                end else if (r_cnt == c_div_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = (BLANK_CYCLES == 0) ? c_st_on : c_st_blank;
                    if (r_idx == c_idx_last) begin
                        // Frame boundary: the only point where a new value
                        // is taken, so a frame never mixes old and new digits.
                        w_idx_nxt   = '0;
                        w_sval_nxt  = value;
                        w_sdp_nxt   = dp_in;
                        w_frame_nxt = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + c_idx_one;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end

            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode, evaluated on next-state values so the registered
    // outputs change on the same edge as the state.
    // ------------------------------------------------------------------
    assign w_nibble = w_sval_nxt[{w_idx_nxt, 2'b00} +: 4];

    hex_to_7seg u_dec (
        .i_nibble (w_nibble),
        .o_seg    (w_glyph)
    );

    always_comb begin
        w_an_on = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_an_on[i] = (w_idx_nxt != c_iw'(i));
        end
    end

    // Digit i>0 is suppressed when it and every more-significant nibble
    // are zero; digit 0 always shows.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
            if (gi == 0 || BLANK_LEADING == 0) begin : g_lz_never
                assign w_lz_blank[gi] = 1'b0;
            end else begin : g_lz_chk
                assign w_lz_blank[gi] = (w_sval_nxt[4*NUM_DIGITS-1:4*gi] == '0);
            end
        end
    endgenerate

    assign w_show = (w_state_nxt == c_st_on) && !w_lz_blank[w_idx_nxt];

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_shadow_val <= '0;
            r_shadow_dp  <= '0;
            r_an         <= '1;
            r_seg        <= c_seg_off;
            r_dp         <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_idx        <= w_idx_nxt;
            r_shadow_val <= w_sval_nxt;
            r_shadow_dp  <= w_sdp_nxt;
            r_frame_done <= w_frame_nxt;
            if (w_show) begin
                r_an  <= w_an_on;
                r_seg <= w_glyph;
                r_dp  <= ~w_sdp_nxt[w_idx_nxt];
            end else begin
                r_an  <= '1;
                r_seg <= c_seg_off;
                r_dp  <= 1'b1;
            end
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_seg_scan_driver                                         |
// | Description : Directed self-checking bench for seg_scan_driver with      |
// |               DIV=10, BLANK_CYCLES=2, leading-zero suppression on.       |
// | Ports       : none                                                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_seg_scan_driver;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int errors = 0;
    int checks = 0;

    seg_scan_driver #(
        .CLK_FREQ_HZ   (1000),
        .REFRESH_HZ    (100),
        .NUM_DIGITS    (4),
        .BLANK_CYCLES  (2),
        .BLANK_LEADING (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .value      (value),
        .dp_in      (dp_in),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] an_e,
                             input logic [6:0] seg_e, input logic dp_e,
                             input logic fd_e);
        check($sformatf("%s_an", tag),  {28'd0, an},         {28'd0, an_e});
        check($sformatf("%s_seg", tag), {25'd0, seg},        {25'd0, seg_e});
        check($sformatf("%s_dp", tag),  {31'd0, dp},         {31'd0, dp_e});
        check($sformatf("%s_fd", tag),  {31'd0, frame_done}, {31'd0, fd_e});
    endtask

    // One full digit slot: 2 blank cycles then 8 lit cycles. fd_e is the
    // expected frame_done in the first blank cycle. When chg_at >= 0 the
    // inputs are changed after that lit cycle.
    task automatic slot(input string tag, input logic [3:0] an_e,
                        input logic [6:0] seg_e, input logic dp_e,
                        input logic fd_e, input int chg_at,
                        input logic [15:0] chg_val, input logic [3:0] chg_dp);
        for (int k = 0; k < 2; k++) begin
            step();
            check_out($sformatf("%s_blank%0d", tag, k), 4'hF, 7'h7F, 1'b1,
                      (k == 0) ? fd_e : 1'b0);
        end
        for (int k = 0; k < 8; k++) begin
            step();
            check_out($sformatf("%s_on%0d", tag, k), an_e, seg_e, dp_e, 1'b0);
            if (k == chg_at) begin
                value = chg_val;
                dp_in = chg_dp;
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        en    = 1'b1;
        value = 16'h1234;
        dp_in = 4'b0001;

        // Reset held three cycles with en high
        for (int k = 0; k < 3; k++) begin
            step();
            check_out($sformatf("reset%0d", k), 4'hF, 7'h7F, 1'b1, 1'b0);
        end
        rst = 1'b0;

        // Frame 1: 1234, dp on digit 0
        slot("f1_d0", 4'hE, 7'h19, 1'b0, 1'b0, -1, 16'h0, 4'h0);
        slot("f1_d1", 4'hD, 7'h30, 1'b1, 1'b0, -1, 16'h0, 4'h0);
        slot("f1_d2", 4'hB, 7'h24, 1'b1, 1'b0, -1, 16'h0, 4'h0);
        slot("f1_d3", 4'h7, 7'h79, 1'b1, 1'b0, -1, 16'h0, 4'h0);

        // Frame 2: value changes during digit 1 lit phase, no visible effect
        slot("f2_d0", 4'hE, 7'h19, 1'b0, 1'b1, -1, 16'h0, 4'h0);
        slot("f2_d1", 4'hD, 7'h30, 1'b1, 1'b0, 3, 16'hABCD, 4'b0001);
        slot("f2_d2", 4'hB, 7'h24, 1'b1, 1'b0, -1, 16'h0, 4'h0);
        slot("f2_d3", 4'h7, 7'h79, 1'b1, 1'b0, -1, 16'h0, 4'h0);

        // Frame 3: ABCD shown as D, C, b, A
        slot("f3_d0", 4'hE, 7'h21, 1'b0, 1'b1, -1, 16'h0, 4'h0);
        slot("f3_d1", 4'hD, 7'h46, 1'b1, 1'b0, -1, 16'h0, 4'h0);
        slot("f3_d2", 4'hB, 7'h03, 1'b1, 1'b0, -1, 16'h0, 4'h0);
        slot("f3_d3", 4'h7, 7'h08, 1'b1, 1'b0, -1, 16'h0, 4'h0);

        // Frame 4: enable dropped during digit 2 lit phase
        slot("f4_d0", 4'hE, 7'h21, 1'b0, 1'b1, -1, 16'h0, 4'h0);
        slot("f4_d1", 4'hD, 7'h46, 1'b1, 1'b0, -1, 16'h0, 4'h0);
        for (int k = 0; k < 2; k++) begin
            step();
            check_out($sformatf("f4_d2_blank%0d", k), 4'hF, 7'h7F, 1'b1, 1'b0);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            check_out($sformatf("f4_d2_on%0d", k), 4'hB, 7'h03, 1'b1, 1'b0);
        end
        en = 1'b0;
        step();
        check_out("en_drop", 4'hF, 7'h7F, 1'b1, 1'b0);
        value = 16'h0050;
        dp_in = 4'b1111;
        step();
        check_out("idle_hold", 4'hF, 7'h7F, 1'b1, 1'b0);
        en = 1'b1;

        // Restart from digit 0 with 0050 latched; leading zeros suppressed
        slot("r1_d0", 4'hE, 7'h40, 1'b0, 1'b0, -1, 16'h0, 4'h0);
        slot("r1_d1", 4'hD, 7'h12, 1'b0, 1'b0, -1, 16'h0, 4'h0);
        slot("r1_d2", 4'hF, 7'h7F, 1'b1, 1'b0, -1, 16'h0, 4'h0);
        slot("r1_d3", 4'hF, 7'h7F, 1'b1, 1'b0, -1, 16'h0, 4'h0);
        slot("r2_d0", 4'hE, 7'h40, 1'b0, 1'b1, -1, 16'h0, 4'h0);
        slot("r2_d1", 4'hD, 7'h12, 1'b0, 1'b0, -1, 16'h0, 4'h0);
        slot("r2_d2", 4'hF, 7'h7F, 1'b1, 1'b0, 0, 16'h1234, 4'b0001);
        slot("r2_d3", 4'hF, 7'h7F, 1'b1, 1'b0, -1, 16'h0, 4'h0);

        // Frame with 1234, reset asserted during digit 3 lit phase
        slot("r3_d0", 4'hE, 7'h19, 1'b0, 1'b1, -1, 16'h0, 4'h0);
        slot("r3_d1", 4'hD, 7'h30, 1'b1, 1'b0, -1, 16'h0, 4'h0);
        slot("r3_d2", 4'hB, 7'h24, 1'b1, 1'b0, -1, 16'h0, 4'h0);
        for (int k = 0; k < 2; k++) begin
            step();
            check_out($sformatf("r3_d3_blank%0d", k), 4'hF, 7'h7F, 1'b1, 1'b0);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            check_out($sformatf("r3_d3_on%0d", k), 4'h7, 7'h79, 1'b1, 1'b0);
        end
        rst = 1'b1;
        step();
        check_out("mid_rst", 4'hF, 7'h7F, 1'b1, 1'b0);
        rst = 1'b0;

        // Restart from digit 0, no frame_done for the aborted frame
        slot("a1_d0", 4'hE, 7'h19, 1'b0, 1'b0, -1, 16'h0, 4'h0);
        slot("a1_d1", 4'hD, 7'h30, 1'b1, 1'b0, -1, 16'h0, 4'h0);
        slot("a1_d2", 4'hB, 7'h24, 1'b1, 1'b0, -1, 16'h0, 4'h0);
        slot("a1_d3", 4'h7, 7'h79, 1'b1, 1'b0, -1, 16'h0, 4'h0);
        slot("a2_d0", 4'hE, 7'h19, 1'b0, 1'b1, -1, 16'h0, 4'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Downstream consumer of the board's clock-division stage. Time-multiplexes a 4-digit, common-anode seven-segment display from a 16-bit hex value.
- Uses an internal per-digit refresh strobe in the single system clock domain. No divided clock is used as a clock.
- Latches the input once per frame, so the display never shows a mix of old and new digits.
- Inserts an anode-off blanking interval at each digit switch to suppress ghosting.

Parameters:
- CLK_FREQ_HZ, 100_000_000, system clock frequency.
- REFRESH_HZ, 1000, digit-slot rate. DIV = CLK_FREQ_HZ/REFRESH_HZ cycles per digit slot.
- NUM_DIGITS, 4, digits scanned.
- BLANK_CYCLES, 16, anode-off cycles at the start of each slot. Elaboration must fail (error) unless DIV >= BLANK_CYCLES+2.
- BLANK_LEADING, 1, when 1 suppress leading zeros.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  scan enable.
- value  in  16  hex value; digit i = value[4i+3:4i].
- dp_in  in  4  decimal point per digit, 1 = lit.
- an  out  4  anodes, active-low, registered.
- seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low, registered.
- dp  out  1  decimal point cathode, active-low, registered.
- frame_done  out  1  one-cycle pulse at the end of each complete frame.

Behaviour:
- Reset values: an=4'b1111, seg=7'h7F, dp=1, frame_done=0. Internal state: cnt=0, idx=0, shadow=0, state=IDLE.
- Reset takes effect at the next clk edge from any state. It overrides en and any in-progress scan.

State machine (IDLE, BLANK, ON):
- IDLE
  - Outputs are at their reset values.
  - If en=1, on that edge: shadow_val<=value, shadow_dp<=dp_in, idx<=0, cnt<=0.
  - Next state is BLANK, or ON if BLANK_CYCLES=0.
- BLANK
  - an=1111, seg=7F, dp=1. cnt increments.
  - When cnt==BLANK_CYCLES-1, go to ON with cnt continuing.
- ON
  - an = ~(1<<idx). seg = decode(shadow nibble idx). dp = ~shadow_dp[idx].
  - When cnt==DIV-1: cnt<=0, go to BLANK, idx<=idx+1 (wraps NUM_DIGITS-1 -> 0).
  - On the wrap edge: shadow<=value/dp_in, and frame_done is asserted for exactly the following cycle.
- en=0 in BLANK or ON: IDLE on the next edge, with outputs blank in the same edge.

Timing:
- Every slot is exactly DIV cycles. A frame is NUM_DIGITS*DIV cycles.
- Outputs change on the same edge as the state; there is no extra latency.

Leading-zero blanking:
- Applies when BLANK_LEADING=1.
- Digit i>0 is blanked if nibbles i..NUM_DIGITS-1 of shadow are all zero. Digit 0 is never blanked.
- A blanked digit keeps its anode high for the whole slot and still consumes DIV cycles.
- A blanked digit's dp is not shown.

Other rules:
- Input changes mid-frame have no visible effect until the next frame boundary.
- Decode: standard hex glyphs 0-F, e.g. 0=7'b1000000, 4=7'b0011001, 5=7'b0010010, 8=7'b0000000.

Decomposition:
- Package seg_pkg:
  - State enum constants (IDLE/BLANK/ON).
  - 16-entry active-low glyph constant table.
  - Function computing the counter width, clog2(DIV).
- Sub-module hex_to_7seg: combinational nibble -> active-low segments, table from seg_pkg. Instantiated once and fed the nibble selected by idx.
- Counter, FSM and shadow registers stay in seg_scan_driver.

Test Plan:
Bench parameters: CLK_FREQ_HZ=1000, REFRESH_HZ=100 (DIV=10), BLANK_CYCLES=2, BLANK_LEADING=1.
- Reset: assert rst 3 cycles with en=1 -> an=1111, seg=7F, dp=1, frame_done=0 while rst is high and on the first cycle after.
- Scan: value=16'h1234, dp_in=0001, en=1 from IDLE ->
  - 2 cycles an=1111, then 8 cycles an=1110, seg=0011001, dp=0;
  - then digits 1..3 in turn (glyphs 3, 2, 1), each slot 10 cycles;
  - frame_done pulses every 40 cycles.
- Leading zeros: value=16'h0050 -> digit 3 and digit 2 slots keep an=1111 for all 10 cycles; digit 1 shows 0010010; digit 0 shows 1000000.
- Tear-free update: change value 16'h1234 -> 16'hABCD during digit 1's ON phase -> digits 2,3 still show 2,1; next frame shows D,C,B,A; change takes effect right after the frame_done edge.
- Enable drop: deassert en during digit 2 ON -> next cycle an=1111, state IDLE. Reassert -> restart at digit 0 with a fresh 2-cycle blank and a newly latched value.
- Mid-scan reset: assert rst during digit 3 ON -> reset values next edge. After release with en=1, scanning restarts from digit 0; no frame_done pulse for the aborted frame.
